// File: rtl/muldiv_units.sv
// muldiv_units: fixed-latency pipelined RV32M arithmetic (signed/unsigned divide, low-word multiply).
// Data paths are free-running; in_valid rides along as a tag and never gates the pipeline.
`default_nettype none

module muldiv_div #(
   parameter bit SIGNED = 1'b1,
   parameter int STAGES = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] dout,
   output logic        valid
);

   localparam int BITS_PER_STAGE = 3;

   // sh holds the not-yet-consumed dividend bits on the left and the quotient
   // bits collected so far on the right; after all stages it is the quotient.
   logic [32:0] sh     [0:STAGES];
   logic [31:0] rem    [0:STAGES];
   logic [31:0] dsr    [0:STAGES];
   logic        neg_q  [0:STAGES];
   logic        neg_r  [0:STAGES];
   logic        dz     [0:STAGES];
   logic        ovf    [0:STAGES];
   logic        vld    [0:STAGES];

   logic        a_neg;
   logic        b_neg;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] q_raw;
   logic [31:0] r_raw;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   function automatic logic [64:0] div_step(
      input logic [32:0] sh_in,
      input logic [31:0] rem_in,
      input logic [31:0] d
   );
      logic [32:0] s;
      logic [32:0] trial;
      logic [31:0] r;
      s = sh_in;
      r = rem_in;
      for (int k = 0; k < BITS_PER_STAGE; k++) begin
         trial = {r, s[32]};
         if (trial >= {1'b0, d}) begin
            trial = trial - {1'b0, d};
            s     = {s[31:0], 1'b1};
         end else begin
            s     = {s[31:0], 1'b0};
         end
         r = trial[31:0];
      end
      return {s, r};
   endfunction

   always_comb begin
      a_neg = SIGNED & a[31];
      b_neg = SIGNED & b[31];
      abs_a = a_neg ? -a : a;
      abs_b = b_neg ? -b : b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= STAGES; i++) begin
            sh[i]    <= '0;
            rem[i]   <= '0;
            dsr[i]   <= '0;
            neg_q[i] <= 1'b0;
            neg_r[i] <= 1'b0;
            dz[i]    <= 1'b0;
            ovf[i]   <= 1'b0;
            vld[i]   <= 1'b0;
         end
      end else begin
         sh[0]    <= {1'b0, abs_a};
         rem[0]   <= '0;
         dsr[0]   <= abs_b;
         neg_q[0] <= a_neg ^ b_neg;
         neg_r[0] <= a_neg;
         dz[0]    <= (b == 32'd0);
         ovf[0]   <= SIGNED & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
         vld[0]   <= in_valid;
         for (int i = 1; i <= STAGES; i++) begin
            {sh[i], rem[i]} <= div_step(sh[i-1], rem[i-1], dsr[i-1]);
            dsr[i]   <= dsr[i-1];
            neg_q[i] <= neg_q[i-1];
            neg_r[i] <= neg_r[i-1];
            dz[i]    <= dz[i-1];
            ovf[i]   <= ovf[i-1];
            vld[i]   <= vld[i-1];
         end
      end
   end

   // A zero divisor leaves the remainder equal to |a|, so only the quotient
   // needs overriding; quotient bit 32 can only ever be set by a zero divisor.
   always_comb begin
      q_raw = sh[STAGES][31:0];
      r_raw = rem[STAGES];
      q_fix = neg_q[STAGES] ? -q_raw : q_raw;
      r_fix = neg_r[STAGES] ? -r_raw : r_raw;
      if (dz[STAGES] | sh[STAGES][32]) begin
         q_fix = 32'hFFFF_FFFF;
      end else if (ovf[STAGES]) begin
         q_fix = 32'h8000_0000;
         r_fix = 32'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout  <= '0;
         valid <= 1'b0;
      end else begin
         dout  <= {q_fix, r_fix};
         valid <= vld[STAGES];
      end
   end

endmodule

module muldiv_units #(
   parameter int DIV_LATENCY = 13,
   parameter int MUL_LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic [63:0] sdiv_dout,
   output logic        sdiv_valid,
   output logic [63:0] udiv_dout,
   output logic        udiv_valid,
   output logic [31:0] mul_p,
   output logic        mul_valid
);

   // Input register and output register bracket the iteration stages.
   localparam int ITER_STAGES = DIV_LATENCY - 2;

   muldiv_div #(.SIGNED(1'b1), .STAGES(ITER_STAGES)) u_sdiv (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (rs1),
      .b        (rs2),
      .dout     (sdiv_dout),
      .valid    (sdiv_valid)
   );

   muldiv_div #(.SIGNED(1'b0), .STAGES(ITER_STAGES)) u_udiv (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (rs1),
      .b        (rs2),
      .dout     (udiv_dout),
      .valid    (udiv_valid)
   );

   logic [31:0]            op_a;
   logic [31:0]            op_b;
   logic [31:0]            pp_lo;
   logic [15:0]            pp_hi;
   logic [MUL_LATENCY-1:0] mul_vld_sr;

   // Low word only: a*b[15:0] in full, plus the low half of a[15:0]*b[31:16].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a       <= '0;
         op_b       <= '0;
         pp_lo      <= '0;
         pp_hi      <= '0;
         mul_p      <= '0;
         mul_vld_sr <= '0;
      end else begin
         op_a       <= rs1;
         op_b       <= rs2;
         pp_lo      <= op_a * {16'd0, op_b[15:0]};
         pp_hi      <= op_a[15:0] * op_b[31:16];
         mul_p      <= pp_lo + {pp_hi, 16'd0};
         mul_vld_sr <= {mul_vld_sr[MUL_LATENCY-2:0], in_valid};
      end
   end

   assign mul_valid = mul_vld_sr[MUL_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_muldiv_units.sv
// tb_muldiv_units: scoreboard bench for muldiv_units; expected results queued at issue, checked on valid.
`default_nettype none

module tb_muldiv_units;

   localparam int DIV_LAT = 13;
   localparam int MUL_LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [63:0] sdiv_dout;
   logic        sdiv_valid;
   logic [63:0] udiv_dout;
   logic        udiv_valid;
   logic [31:0] mul_p;
   logic        mul_valid;

   muldiv_units dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .rs1        (rs1),
      .rs2        (rs2),
      .sdiv_dout  (sdiv_dout),
      .sdiv_valid (sdiv_valid),
      .udiv_dout  (udiv_dout),
      .udiv_valid (udiv_valid),
      .mul_p      (mul_p),
      .mul_valid  (mul_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [63:0] val;
   } exp_t;

   exp_t sq[$];
   exp_t uq[$];
   exp_t mq[$];

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int div_pulses = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ref_sdiv(input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] q;
      logic signed [31:0] r;
      if (b == 0) return {32'hFFFF_FFFF, a};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {q, r};
   endfunction

   function automatic logic [63:0] ref_udiv(input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return {32'hFFFF_FFFF, a};
      return {a / b, a % b};
   endfunction

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      return {32'd0, p[31:0]};
   endfunction

   task automatic issue(input logic v, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = v;
      rs1      = a;
      rs2      = b;
      if (v) begin
         e.due = cyc + DIV_LAT; e.val = ref_sdiv(a, b); sq.push_back(e);
         e.due = cyc + DIV_LAT; e.val = ref_udiv(a, b); uq.push_back(e);
         e.due = cyc + MUL_LAT; e.val = ref_mul(a, b);  mq.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (sdiv_valid || udiv_valid) div_pulses++;
         if (sdiv_valid) begin
            if (sq.size() == 0) check_val("sdiv_spurious", 1, 0);
            else begin
               e = sq.pop_front();
               check_val("sdiv_latency", cyc, e.due);
               check_val("sdiv_dout", sdiv_dout, e.val);
            end
         end else if (sq.size() != 0 && sq[0].due <= cyc) begin
            check_val("sdiv_missing", 0, 1);
            void'(sq.pop_front());
         end
         if (udiv_valid) begin
            if (uq.size() == 0) check_val("udiv_spurious", 1, 0);
            else begin
               e = uq.pop_front();
               check_val("udiv_latency", cyc, e.due);
               check_val("udiv_dout", udiv_dout, e.val);
            end
         end else if (uq.size() != 0 && uq[0].due <= cyc) begin
            check_val("udiv_missing", 0, 1);
            void'(uq.pop_front());
         end
         if (mul_valid) begin
            if (mq.size() == 0) check_val("mul_spurious", 1, 0);
            else begin
               e = mq.pop_front();
               check_val("mul_latency", cyc, e.due);
               check_val("mul_p", {32'd0, mul_p}, e.val);
            end
         end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            check_val("mul_missing", 0, 1);
            void'(mq.pop_front());
         end
      end
   end

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_sdiv"}, sdiv_dout, 64'd0);
      check_val({tag, "_udiv"}, udiv_dout, 64'd0);
      check_val({tag, "_mul"}, {32'd0, mul_p}, 64'd0);
      check_val({tag, "_valids"}, {61'd0, sdiv_valid, udiv_valid, mul_valid}, 64'd0);
   endtask

   initial begin
      #2 rst = 1'b1;
      #1 check_zero_outputs("reset_state");
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      // Directed vectors
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      issue(1'b1, 32'd5, 32'd0);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(1'b1, 32'hFFFF_FFFF, 32'd3);
      issue(1'b1, 32'h0001_2345, 32'h0001_0000);
      issue(1'b1, 32'hFFFF_FFFB, 32'd0);
      issue(1'b1, 32'd7, 32'hFFFF_FFFE);
      issue(1'b0, 32'd100, 32'd7);
      issue(1'b1, 32'd0, 32'd9);

      // Constant operands held for several cycles
      for (int i = 0; i < 5; i++) issue(1'b1, 32'hDEAD_BEEF, 32'h0000_1234);

      // Back-to-back random stream
      for (int i = 0; i < 20; i++) issue(1'b1, $urandom, (i % 4 == 0) ? $urandom_range(1, 100) : $urandom);

      issue(1'b0, 32'd0, 32'd0);
      repeat (DIV_LAT + 3) @(posedge clk);
      #1;
      check_val("drain_queues", sq.size() + uq.size() + mq.size(), 0);

      // Reset while a divide is in flight
      issue(1'b1, 32'd1000, 32'd7);
      issue(1'b0, 32'd0, 32'd0);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1 check_zero_outputs("reset_midflight");
      sq.delete();
      uq.delete();
      mq.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      div_pulses = 0;
      repeat (DIV_LAT + 5) @(posedge clk);
      #1;
      check_val("post_reset_div_pulses", div_pulses, 0);

      // Pipeline recovers after reset
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      issue(1'b0, 32'd0, 32'd0);
      repeat (DIV_LAT + 3) @(posedge clk);
      #1;
      check_val("final_drain", sq.size() + uq.size() + mq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
